// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants, types and helpers for the LED PWM driver.
//   PWM_CNT_LAST     : last PWM counter value; the period is 255 ticks (0..254)
//   PWM_DUTY_MAX     : largest duty value; it keeps the output high all period
//   duty_t           : 8-bit duty word as delivered by the duty PIO
//   duty_step_toward : moves a duty value one step toward a target, never past it
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_CNT_LAST = 254;
  localparam int PWM_DUTY_MAX = 255;

  typedef logic [7:0] duty_t;

  // The direction is decided from the current target on every call, so a
  // target that moves mid-ramp reverses the ramp without overshoot. The
  // +1 only happens when tgt > cur (so cur < 255) and the -1 only when
  // tgt < cur (so cur > 0): the result always stays within 0..255.
  function automatic duty_t duty_step_toward(input duty_t cur, input duty_t tgt);
    duty_t res;
    res = cur;
    if (tgt > cur) begin
      res = cur + 8'd1;
    end else if (tgt < cur) begin
      res = cur - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// Prescaler producing one PWM tick every PRESCALE_DIV system clocks.
//   clk_clk       : in  system clock
//   reset_reset_n : in  asynchronous active-low reset
//   enable_i      : in  1 = count; 0 = prescaler held at 0 and no ticks
//   tick          : out one-clock strobe in the last prescaler count
// -----------------------------------------------------------------------------
module pwm_tick_gen #(
  parameter int PRESCALE_DIV = 196
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic enable_i,
  output logic tick
);

  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_pre_last;

  assign w_pre_last = (r_pre_cnt == PRE_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pre_cnt <= '0;
    end else if (!enable_i || w_pre_last) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  assign tick = w_pre_last & enable_i;

endmodule

// File: rtl/pwm_led_driver.sv
// -----------------------------------------------------------------------------
// pwm_led_driver
// Turns the 8-bit duty word from the processor PIO into a period-synchronous
// PWM waveform for the board LEDs, with optional slew-limited duty ramping.
//   clk_clk       : in  system clock (same domain as the processor system)
//   reset_reset_n : in  asynchronous active-low reset
//   enable_i      : in  1 = run; 0 = output low, counters held at 0
//   duty_i        : in  target duty 0..255, sampled every clock
//   pwm_o         : out registered PWM output
//   period_end_o  : out one-clock pulse in the cycle the PWM counter reads 0
//   duty_cur_o    : out duty currently applied
//   busy_o        : out 1 while the applied duty differs from the target
// -----------------------------------------------------------------------------
module pwm_led_driver
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 196,
  parameter bit RAMP_EN      = 1'b1,
  parameter int RAMP_PERIODS = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       enable_i,
  input  logic [7:0] duty_i,
  output logic       pwm_o,
  output logic       period_end_o,
  output logic [7:0] duty_cur_o,
  output logic       busy_o
);

  localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
  localparam duty_t CNT_LAST = duty_t'(PWM_CNT_LAST);

  logic              w_tick;
  logic              w_wrap;
  duty_t             w_duty_next;
  logic [RAMP_W-1:0] w_ramp_cnt_next;

  duty_t             r_pwm_cnt;
  duty_t             r_duty_cur;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic              r_pwm;
  logic              r_period_end;
  logic              r_busy;

  pwm_tick_gen #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_tick_gen (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable_i      (enable_i),
    .tick          (w_tick)
  );

  // w_tick already includes enable_i, so a wrap can never occur while disabled.
  assign w_wrap = w_tick && (r_pwm_cnt == CNT_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_pwm_cnt <= '0;
    end else if (!enable_i) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= (r_pwm_cnt == CNT_LAST) ? '0 : r_pwm_cnt + 8'd1;
    end
  end

  // Duty only moves at the period wrap, so the new value takes effect exactly
  // when the counter returns to 0 and a period is never cut short or stretched.
  always_comb begin
    w_duty_next     = r_duty_cur;
    w_ramp_cnt_next = r_ramp_cnt;
    if (!enable_i) begin
      w_ramp_cnt_next = '0;
    end else if (w_wrap) begin
      if (!RAMP_EN) begin
        w_duty_next = duty_i;
      end else if (r_duty_cur == duty_i) begin
        w_ramp_cnt_next = '0;
      end else if (r_ramp_cnt == RAMP_LAST) begin
        w_ramp_cnt_next = '0;
        w_duty_next     = duty_step_toward(r_duty_cur, duty_i);
      end else begin
        w_ramp_cnt_next = r_ramp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_duty_cur   <= '0;
      r_ramp_cnt   <= '0;
      r_pwm        <= 1'b0;
      r_period_end <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_duty_cur   <= w_duty_next;
      r_ramp_cnt   <= w_ramp_cnt_next;
      // Counter tops out at 254, so duty 255 is high for the whole period.
      r_pwm        <= enable_i && (r_pwm_cnt < r_duty_cur);
      r_period_end <= w_wrap;
      r_busy       <= (r_duty_cur != duty_i);
    end
  end

  assign pwm_o        = r_pwm;
  assign period_end_o = r_period_end;
  assign duty_cur_o   = r_duty_cur;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_pwm_led_driver.sv
module tb_pwm_led_driver;
  import pwm_pkg::*;

  localparam int DIV = 2;
  localparam int RP  = 2;
  localparam int PER = DIV * 255;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] duty  = 8'd0;

  logic [1:0] pwm;
  logic [1:0] pe;
  logic [1:0] busy;
  logic [7:0] dc [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: immediate duty update; dut1: ramped duty update. Shared stimulus.
  pwm_led_driver #(.PRESCALE_DIV(DIV), .RAMP_EN(1'b0), .RAMP_PERIODS(RP)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable_i(en), .duty_i(duty),
    .pwm_o(pwm[0]), .period_end_o(pe[0]), .duty_cur_o(dc[0]), .busy_o(busy[0]));

  pwm_led_driver #(.PRESCALE_DIV(DIV), .RAMP_EN(1'b1), .RAMP_PERIODS(RP)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable_i(en), .duty_i(duty),
    .pwm_o(pwm[1]), .period_end_o(pe[1]), .duty_cur_o(dc[1]), .busy_o(busy[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos = enabled clocks elapsed in the current period (clock-level position).
  // The PWM tick index within the period is pos/DIV; the period wraps after PER clocks.
  int   pos;
  int   m_duty  [2];
  int   m_wraps [2];
  logic e_pwm   [2];
  logic e_pe    [2];
  logic e_busy  [2];
  bit   model_ok = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model_blk
    int  tick_idx;
    bit  wrap;
    if (!rst_n) begin
      pos = 0;
      for (int i = 0; i < 2; i++) begin
        m_duty[i] = 0; m_wraps[i] = 0;
        e_pwm[i] = 1'b0; e_pe[i] = 1'b0; e_busy[i] = 1'b0;
      end
      model_ok = 1'b1;
    end else begin
      tick_idx = pos / DIV;
      wrap     = en && (pos == PER - 1);
      for (int i = 0; i < 2; i++) begin
        e_pwm[i]  = en && (tick_idx < m_duty[i]);
        e_pe[i]   = wrap;
        e_busy[i] = (m_duty[i] != int'(duty));
        if (!en) begin
          m_wraps[i] = 0;
        end else if (wrap) begin
          if (i == 0) begin
            m_duty[i] = int'(duty);
          end else if (m_duty[i] == int'(duty)) begin
            m_wraps[i] = 0;
          end else begin
            m_wraps[i]++;
            if (m_wraps[i] == RP) begin
              m_wraps[i] = 0;
              m_duty[i]  = m_duty[i] + ((int'(duty) > m_duty[i]) ? 1 : -1);
            end
          end
        end
      end
      pos = en ? (pos + 1) % PER : 0;
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("dut0_outputs", {20'd0, pwm[0], pe[0], busy[0], 1'b0, dc[0]},
            {20'd0, e_pwm[0], e_pe[0], e_busy[0], 1'b0, 8'(m_duty[0])});
      check("dut1_outputs", {20'd0, pwm[1], pe[1], busy[1], 1'b0, dc[1]},
            {20'd0, e_pwm[1], e_pe[1], e_busy[1], 1'b0, 8'(m_duty[1])});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_pe(input int which);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 2 * PER && !seen; n++) begin
      @(negedge clk);
      if (pe[which]) seen = 1'b1;
    end
    if (!seen) check("wait_period_end_timeout", 32'd0, 32'd1);
  endtask

  // Counts the clocks after a period_end pulse up to and including the next
  // one, plus how many of them had pwm_o high. Optionally changes duty_i
  // after change_at clocks.
  task automatic measure(input int which, input int change_at, input logic [7:0] new_duty,
                         output int len, output int highs);
    bit seen;
    seen = 1'b0; len = 0; highs = 0;
    while (!seen && len < 2 * PER) begin
      @(negedge clk);
      len++;
      if (pwm[which]) highs++;
      if (pe[which]) seen = 1'b1;
      if (len == change_at) duty = new_duty;
    end
    if (!seen) check("measure_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input logic [7:0] d);
    @(negedge clk);
    #2 rst_n = 1'b0;
    duty = d;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  len, hi, cnt;
    bit  noisy;
    int  exp_dc_b [6];
    int  exp_dc_c [5];
    exp_dc_b = '{0, 1, 1, 2, 2, 3};
    exp_dc_c = '{2, 1, 1, 0, 0};

    repeat (3) @(negedge clk);
    check("reset_outputs_dut0", {pwm[0], pe[0], busy[0], dc[0]}, 32'd0);
    check("reset_outputs_dut1", {pwm[1], pe[1], busy[1], dc[1]}, 32'd0);
    #2 rst_n = 1'b1;

    // ---- A: immediate update, duty 64 / 200 / 0 / 255 ----
    @(negedge clk);
    duty = 8'd64; en = 1'b1;
    wait_pe(0);
    check("A_dc_after_wrap1", dc[0], 32'd64);
    measure(0, 100, 8'd200, len, hi);
    check("A_period_len", len, PER);
    check("A_high_duty64_with_midchange", hi, 32'd128);
    check("A_dc_200_at_boundary", dc[0], 32'd200);
    @(negedge clk);
    check("A_pwm_high_at_cnt0_duty200", pwm[0], 1'b1);
    measure(0, 9, 8'd0, len, hi);
    check("A_high_duty200", hi + 1, 32'd400);
    measure(0, 10, 8'd255, len, hi);
    check("A_high_duty0", hi, 32'd0);
    measure(0, -1, 8'd0, len, hi);
    check("A_high_duty255", hi, PWM_DUTY_MAX * DIV);
    check("A_period_len_255", len, PER);

    // ---- B: ramp 0 -> 3 ----
    do_reset(8'd3);
    for (int k = 0; k < 6; k++) begin
      wait_pe(1);
      check($sformatf("B_dc_wrap%0d", k + 1), dc[1], exp_dc_b[k]);
      check($sformatf("B_busy_wrap%0d", k + 1), busy[1], 1'b1);
    end
    @(negedge clk);
    check("B_busy_clear", busy[1], 1'b0);
    wait_pe(1);
    check("B_dc_hold", dc[1], 32'd3);

    // ---- C: reverse mid-ramp at duty_cur=2 ----
    do_reset(8'd10);
    repeat (4) wait_pe(1);
    check("C_dc_before_reverse", dc[1], 32'd2);
    duty = 8'd0;
    for (int k = 0; k < 5; k++) begin
      wait_pe(1);
      check($sformatf("C_dc_wrap%0d", k + 5), dc[1], exp_dc_c[k]);
    end
    check("C_busy_clear", busy[1], 1'b0);

    // ---- D: disable for 1000 clocks mid-period at duty 100 ----
    do_reset(8'd100);
    wait_pe(0);
    check("D_dc_100", dc[0], 32'd100);
    repeat (150) @(negedge clk);
    en = 1'b0;
    noisy = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (pwm != 2'b00 || pe != 2'b00) noisy = 1'b1;
    end
    check("D_quiet_while_disabled", noisy, 1'b0);
    check("D_dc_held", dc[0], 32'd100);
    en = 1'b1;
    @(negedge clk);
    check("D_pwm_restart_high", pwm[0], 1'b1);
    cnt = 1;
    while (!pe[0] && cnt < 2 * PER) begin
      @(negedge clk);
      cnt++;
    end
    check("D_first_period_len", cnt, PER);
    check("D_dc_after_reenable", dc[0], 32'd100);

    // ---- E: asynchronous reset mid-ramp ----
    do_reset(8'd200);
    repeat (3) wait_pe(1);
    check("E_dc1_mid_ramp", dc[1], 32'd1);
    repeat (100) @(negedge clk);
    check("E_pwm0_before_reset", pwm[0], 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("E_async_clear_dut0", {pwm[0], pe[0], busy[0], dc[0]}, 32'd0);
    check("E_async_clear_dut1", {pwm[1], pe[1], busy[1], dc[1]}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_pe(0);
    check("E_dc0_after_restart", dc[0], 32'd200);
    check("E_dc1_restart_from_0", dc[1], 32'd0);
    wait_pe(1);
    check("E_dc1_second_wrap", dc[1], 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
